// File: rtl/arr_reg_bank_loader_pkg.sv
// Shared types and helpers for the bank-register loader: FSM states,
// release-mode constants and a constant-foldable ceil(log2) helper.
package arr_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int EMIT_STAGGER = 0;
    localparam int EMIT_ALL     = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arr_reg_bank.sv
// One bank of WORDS_PER_BANK word registers; contents are visible on
// out_data only once the bank has been released (freeze high).
module arr_reg_bank
    import arr_reg_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_BANK = 4,
    parameter int WSEL_W         = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             wr_en,
    input  logic [WSEL_W-1:0]                wr_sel,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             freeze,
    output logic [WORDS_PER_BANK*DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] words [WORDS_PER_BANK];

    // freeze reflects the release state before this edge, so a write landing
    // on the release edge itself still goes in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WORDS_PER_BANK; w++) begin
                words[w] <= '0;
            end
        end else if (clr) begin
            for (int w = 0; w < WORDS_PER_BANK; w++) begin
                words[w] <= '0;
            end
        end else if (wr_en && !freeze) begin
            words[wr_sel] <= wr_data;
        end
    end

    always_comb begin
        out_data = '0;
        for (int w = 0; w < WORDS_PER_BANK; w++) begin
            if (freeze) begin
                out_data[w*DATA_W +: DATA_W] = words[w];
            end
        end
    end

endmodule

// File: rtl/arr_reg_bank_loader.sv
// Bank-register array loader: collects words into banks, then releases the
// banks to the compute stage in order and freezes each released bank.
module arr_reg_bank_loader
    import arr_reg_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_BANK = 4,
    parameter int NUM_BANKS      = 4,
    parameter int READY_AFTER    = 2,
    parameter int EMIT_MODE      = 0,
    localparam int WSEL_W = clog2(WORDS_PER_BANK),
    localparam int BSEL_W = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1,
    localparam int IDX_W  = WSEL_W + BSEL_W
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       clr,
    input  logic                                       start,
    input  logic                                       wr_valid,
    output logic                                       wr_ready,
    input  logic [IDX_W-1:0]                           wr_index,
    input  logic [DATA_W-1:0]                          wr_data,
    output logic [NUM_BANKS*WORDS_PER_BANK*DATA_W-1:0] out_data,
    output logic [NUM_BANKS-1:0]                       bank_emit,
    output logic                                       ready,
    output logic                                       done,
    output logic                                       wr_drop,
    output state_t                                     state_dbg
);

    localparam int                CNT_W      = clog2(NUM_BANKS + 1);
    localparam int                SEL_SPAN   = 1 << BSEL_W;
    localparam logic [BSEL_W:0]   BANK_LIMIT = (BSEL_W + 1)'(NUM_BANKS);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(NUM_BANKS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(NUM_BANKS);

    state_t               state, state_n;
    logic [CNT_W-1:0]     counter, counter_n;
    logic [NUM_BANKS-1:0] emit_n;
    logic                 ready_n, done_n, drop_n;
    logic [BSEL_W-1:0]    bank_sel;
    logic [WSEL_W-1:0]    word_sel;
    logic [SEL_SPAN-1:0]  emit_ext;
    logic                 in_range, accept;

    // Write handshake: a word transfers on any edge where wr_valid && wr_ready;
    // wr_ready depends only on wr_index and the current release flags, never
    // on wr_valid. A request seen with wr_ready low is dropped, not retried.
    assign bank_sel  = wr_index[IDX_W-1 -: BSEL_W];
    assign word_sel  = wr_index[WSEL_W-1:0];
    assign emit_ext  = SEL_SPAN'(bank_emit);
    assign in_range  = {1'b0, bank_sel} < BANK_LIMIT;
    assign wr_ready  = in_range && !emit_ext[bank_sel];
    assign accept    = wr_valid && wr_ready;
    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        counter_n = counter;
        emit_n    = bank_emit;
        case (state)
            IDLE: begin
                if (start) begin
                    if (EMIT_MODE == EMIT_ALL) begin
                        emit_n    = '1;
                        counter_n = CNT_MAX;
                        state_n   = DONE;
                    end else begin
                        emit_n[0] = 1'b1;
                        counter_n = CNT_W'(1);
                        state_n   = (NUM_BANKS == 1) ? DONE : EMIT;
                    end
                end
            end
            EMIT: begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (counter == CNT_W'(b)) begin
                        emit_n[b] = 1'b1;
                    end
                end
                if (counter != CNT_MAX) begin
                    counter_n = counter + CNT_W'(1);
                end
                if (counter == CNT_LAST) begin
                    state_n = DONE;
                end
            end
            default: ;
        endcase
        // Banks release strictly in index order, so one flag stands for the count.
        ready_n = ready | emit_n[READY_AFTER-1];
        done_n  = done | emit_n[NUM_BANKS-1];
        drop_n  = wr_drop | (wr_valid & ~wr_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            counter   <= '0;
            bank_emit <= '0;
            ready     <= 1'b0;
            done      <= 1'b0;
            wr_drop   <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            counter   <= '0;
            bank_emit <= '0;
            ready     <= 1'b0;
            done      <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            state     <= state_n;
            counter   <= counter_n;
            bank_emit <= emit_n;
            ready     <= ready_n;
            done      <= done_n;
            wr_drop   <= drop_n;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        arr_reg_bank #(
            .DATA_W         (DATA_W),
            .WORDS_PER_BANK (WORDS_PER_BANK),
            .WSEL_W         (WSEL_W)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .wr_en    (accept && (bank_sel == BSEL_W'(b))),
            .wr_sel   (word_sel),
            .wr_data  (wr_data),
            .freeze   (bank_emit[b]),
            .out_data (out_data[b*WORDS_PER_BANK*DATA_W +: WORDS_PER_BANK*DATA_W])
        );
    end

endmodule

// File: doc/arr_reg_bank_loader.md
Name: arr_reg_bank_loader

Overview:
- Parametrised bank-register array for the state-vector datapath.
- Collects DATA_W words, addressed by a flat word index, into NUM_BANKS banks of WORDS_PER_BANK words each.
- On start, releases the banks to the downstream compute stage in a fixed sequence, one bank per cycle or all at once, then freezes each released bank against further writes.
- Provides a valid/ready write handshake, an early-ready threshold and a completion flag.

Parameters:
DATA_W, 32, width of one word.
WORDS_PER_BANK, 4, words per bank (power of two, >=2).
NUM_BANKS, 4, number of banks (>=1).
READY_AFTER, 2, count of released banks at which ready asserts (1..NUM_BANKS).
EMIT_MODE, 0, 0 = staggered (one bank per cycle); 1 = all banks released on one edge.
Derived (not overridable): WSEL_W = clog2(WORDS_PER_BANK), BSEL_W = max(1, clog2(NUM_BANKS)), IDX_W = WSEL_W + BSEL_W.

Ports:
clk  in  1  clock; all state changes on posedge.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous clear; same effect as reset, applied at the next edge.
start  in  1  level; begins release when sampled high in IDLE.
wr_valid  in  1  write request.
wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready.
wr_index  in  IDX_W  flat word index; upper BSEL_W bits select the bank, lower WSEL_W bits select the word.
wr_data  in  DATA_W  write word.
out_data  out  NUM_BANKS*WORDS_PER_BANK*DATA_W  bank b, word w occupies bits [(b*WORDS_PER_BANK+w)*DATA_W +: DATA_W].
bank_emit  out  NUM_BANKS  per-bank released flag.
ready  out  1  at least READY_AFTER banks released.
done  out  1  all banks released.
wr_drop  out  1  sticky; a write was attempted to a frozen or out-of-range bank.

Behaviour:
- Reset (rst_n low, asynchronous) or clr (synchronous):
  - all word registers = 0
  - bank_emit = 0, ready = 0, done = 0, wr_drop = 0
  - counter = 0, state = IDLE
  - clr has priority over every other input on the same edge.
- Out-of-range bank: a bank select >= NUM_BANKS is out of range.
- wr_ready (combinational): 1 when the target bank is in range and bank_emit[target] is 0; otherwise 0.
- Write: on wr_valid && wr_ready, the word register is updated at the next edge. Latency 1; no back-pressure other than the freeze.
- wr_drop: on wr_valid && !wr_ready, the word is discarded and wr_drop is set at the next edge. It stays set until reset or clr.
- out_data: a bank's field shows its register contents only while its bank_emit bit is 1; otherwise the field is all zeros.
- State machine:
  - IDLE: start=1 moves to EMIT at the next edge.
    - EMIT_MODE=0: bank_emit[0] sets on that same edge and counter becomes 1.
    - EMIT_MODE=1: all bank_emit bits set on that edge; ready and done also set on that edge; state goes directly to DONE.
  - EMIT (EMIT_MODE=0 only):
    - Each edge sets bank_emit[counter] and increments counter.
    - After bank NUM_BANKS-1 is set, state moves to DONE and done sets on that same edge.
    - Total: start sampled at edge k gives bank i set at edge k+i and done at edge k+NUM_BANKS-1.
    - NUM_BANKS=1: the first edge goes straight to DONE.
  - DONE: holds all outputs until reset or clr. start is ignored.
  - start in EMIT or DONE is ignored. Deasserting start mid-EMIT does not stop the sequence.
- ready sets on the same edge that bank_emit[READY_AFTER-1] sets, and holds until reset or clr.
- Simultaneous write and release on the same bank: the write is accepted, because wr_ready uses the current bank_emit. The new word becomes visible together with the release.
- Reset asserted mid-EMIT: outputs clear immediately (asynchronous). After rst_n deasserts, the block restarts from IDLE.
- counter width: clog2(NUM_BANKS+1). The counter saturates and never wraps.

Decomposition:
- Package arr_reg_pkg:
  - state enum {IDLE, EMIT, DONE} (2 bits)
  - EMIT_STAGGER = 0, EMIT_ALL = 1 constants
  - clog2 helper function
- Sub-module arr_reg_bank, one instance per bank via generate:
  - holds WORDS_PER_BANK x DATA_W registers, with write enable, word select and freeze input (freeze = bank_emit)
  - outputs its masked packed data
- The top level holds the FSM, counter, handshake, ready/done/wr_drop.

Test Plan:
1. Default params: write index 0..15 with data 0x100+idx, then start=1 at edge k → bank_emit = 0001, 0011, 0111, 1111 at edges k..k+3; ready high from k+1; done high from k+3; out_data word 5 = 0x105.
2. After bank 0 is released, wr_valid with index 2 and data 0xDEAD → wr_ready=0, word 2 stays 0x102, wr_drop=1 next edge; a write to index 12 (bank 3) at edge k+1 is accepted and bank 3 word 0 reads 0xDEAD after edge k+3.
3. EMIT_MODE=1, NUM_BANKS=8, WORDS_PER_BANK=2 → one edge after start, bank_emit = 0xFF and ready=done=1; index 15 write before start appears at bits [15*32 +: 32].
4. NUM_BANKS=3, write to index 12 (bank 3, out of range) → wr_ready=0, wr_drop=1, no register changes.
5. Pull rst_n low asynchronously mid-EMIT after bank 1 → all outputs 0 immediately; after release, start → sequence restarts at bank 0. Repeat with clr high at the edge where start is high → stays IDLE, all outputs 0.
6. start pulse in DONE, and start held high across EMIT → no effect; done stays 1; bank_emit stays all ones.
